// File: rtl/bin_display_scan_ctrl.sv
// Purpose: accepts a 0..15 binary value, splits it into tens/units BCD and scans both digits onto one shared segment decoder.
// Latency: new value on bcd_digit/digit_sel one cycle after the transfer edge (one CONVERT cycle).
// Backpressure: bin_ready drops for the single CONVERT cycle, so at most one value every 2 cycles is taken.
module bin_display_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bin_valid,
  input  logic [3:0] bin_data,
  output logic       bin_ready,
  output logic [3:0] bcd_digit,
  output logic [1:0] digit_sel,
  output logic       disp_valid
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SCAN    = 2'd2
  } state_t;

  // slot encoding: 0 = units digit, 1 = tens digit
  state_t        state, state_nxt;
  logic [3:0]    value_reg, value_nxt;
  logic [3:0]    tens_reg, tens_nxt;
  logic [3:0]    units_reg, units_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          slot, slot_nxt;
  logic [3:0]    bcd_nxt;
  logic [1:0]    sel_nxt;
  logic          dv_nxt;
  logic          xfer;

  // Ready is purely a function of state: only the CONVERT bubble refuses input.
  assign bin_ready = (state != CONVERT);
  assign xfer      = bin_valid && bin_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg  <= 4'd0;
      tens_reg   <= 4'd0;
      units_reg  <= 4'd0;
      cnt        <= '0;
      slot       <= 1'b0;
      bcd_digit  <= 4'd0;
      digit_sel  <= 2'b00;
      disp_valid <= 1'b0;
    end else begin
      value_reg  <= value_nxt;
      tens_reg   <= tens_nxt;
      units_reg  <= units_nxt;
      cnt        <= cnt_nxt;
      slot       <= slot_nxt;
      bcd_digit  <= bcd_nxt;
      digit_sel  <= sel_nxt;
      disp_valid <= dv_nxt;
    end
  end

  // Next-state, conversion and next-output decode; outputs hold unless a slot changes.
  always_comb begin
    state_nxt = state;
    value_nxt = value_reg;
    tens_nxt  = tens_reg;
    units_nxt = units_reg;
    cnt_nxt   = cnt;
    slot_nxt  = slot;
    bcd_nxt   = bcd_digit;
    sel_nxt   = digit_sel;
    dv_nxt    = disp_valid;

    case (state)
      IDLE: begin
        if (xfer) begin
          value_nxt = bin_data;
          state_nxt = CONVERT;
        end
      end

      CONVERT: begin
        // Values 10..15 have tens digit 1; the subtraction cannot wrap here.
        if (value_reg > 4'd9) begin
          tens_nxt  = 4'd1;
          units_nxt = value_reg - 4'd10;
        end else begin
          tens_nxt  = 4'd0;
          units_nxt = value_reg;
        end
        cnt_nxt   = '0;
        slot_nxt  = 1'b0;
        sel_nxt   = 2'b01;
        bcd_nxt   = units_nxt;
        dv_nxt    = 1'b1;
        state_nxt = SCAN;
      end

      SCAN: begin
        if (xfer) begin
          // Old digits stay on the display through the CONVERT cycle.
          value_nxt = bin_data;
          state_nxt = CONVERT;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          slot_nxt = ~slot;
          if (slot) begin
            sel_nxt = 2'b01;
            bcd_nxt = units_reg;
          end else if (tens_reg == 4'd0) begin
            // Leading-zero blanking: the tens slot still takes its full time, unlit.
            sel_nxt = 2'b00;
            bcd_nxt = 4'd0;
          end else begin
            sel_nxt = 2'b10;
            bcd_nxt = tens_reg;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
